// File: rtl/sha256_pkg.sv
// Shared constants and helpers for the SHA-256 output stages.
package sha256_pkg;

  localparam int unsigned DIGEST_W     = 256;
  localparam int unsigned DIGEST_BYTES = 32;
  localparam int unsigned HEX_CHARS    = 64;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h57 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/sha256_digest_serializer.sv
// Captures a 256-bit digest and streams it MSB-first as raw bytes or lowercase ASCII hex
// over a valid/ready byte interface.
module sha256_digest_serializer
  import sha256_pkg::*;
#(
  parameter bit HEX_ASCII = 1'b0,
  parameter bit APPEND_LF = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIGEST_W-1:0] hash_in,
  input  logic                hash_valid,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned NUM_SYM  = HEX_ASCII ? (APPEND_LF ? HEX_CHARS + 1 : HEX_CHARS)
                                               : DIGEST_BYTES;
  localparam logic [6:0]  LAST_CNT = 7'(NUM_SYM - 1);
  localparam logic [6:0]  LF_CNT   = 7'(HEX_CHARS);
  localparam int unsigned SHIFT_W  = HEX_ASCII ? 4 : 8;

  logic [0:0]          state_q, state_d;
  logic [DIGEST_W-1:0] hold_q, hold_d;
  logic [6:0]          cnt_q, cnt_d;
  logic                overrun_q, overrun_d;

  logic sending, fire, last_fire;

  assign sending   = (state_q == ST_SEND);
  assign fire      = sending && out_ready;
  assign last_fire = fire && (cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    if (!sending) begin
      if (hash_valid) begin
        hold_d  = hash_in;
        cnt_d   = '0;
        state_d = ST_SEND;
      end
    end else if (last_fire) begin
      // A pulse coinciding with the final handshake is accepted back-to-back.
      if (hash_valid) begin
        hold_d = hash_in;
        cnt_d  = '0;
      end else begin
        hold_d  = '0;
        state_d = ST_IDLE;
      end
    end else begin
      if (fire) begin
        hold_d = hold_q << SHIFT_W;
        cnt_d  = cnt_q + 7'd1;
      end
      if (hash_valid) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    out_data = 8'h00;
    if (sending) begin
      if (HEX_ASCII && APPEND_LF && (cnt_q == LF_CNT)) begin
        out_data = 8'h0A;
      end else if (HEX_ASCII) begin
        out_data = nibble_to_ascii(hold_q[DIGEST_W-1 -: 4]);
      end else begin
        out_data = hold_q[DIGEST_W-1 -: 8];
      end
    end
  end

  assign out_valid = sending;
  assign busy      = sending;
  assign out_last  = sending && (cnt_q == LAST_CNT);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Scoreboard bench: a binary and a hex+LF serializer driven with directed digests.
module tb_sha256_digest_serializer;

  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ONES = {32{8'h11}};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] bin_hash = '0, hex_hash = '0;
  logic         bin_hv = 1'b0, hex_hv = 1'b0;
  logic         rdy_bin = 1'b0, rdy_hex = 1'b0;
  logic [7:0]   bin_data, hex_data;
  logic         bin_valid, hex_valid, bin_last, hex_last;
  logic         bin_busy, hex_busy, bin_ovr, hex_ovr;

  int n_cmp = 0;
  int n_fail = 0;

  // Each entry is {last, data}.
  logic [8:0] exp_bin[$];
  logic [8:0] exp_hex[$];

  always #5 clk = ~clk;

  sha256_digest_serializer #(.HEX_ASCII(1'b0), .APPEND_LF(1'b0)) u_bin (
    .clk(clk), .reset(reset), .hash_in(bin_hash), .hash_valid(bin_hv),
    .out_data(bin_data), .out_valid(bin_valid), .out_ready(rdy_bin), .out_last(bin_last),
    .busy(bin_busy), .overrun(bin_ovr)
  );

  sha256_digest_serializer #(.HEX_ASCII(1'b1), .APPEND_LF(1'b1)) u_hex (
    .clk(clk), .reset(reset), .hash_in(hex_hash), .hash_valid(hex_hv),
    .out_data(hex_data), .out_valid(hex_valid), .out_ready(rdy_hex), .out_last(hex_last),
    .busy(hex_busy), .overrun(hex_ovr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  task automatic push_bin(input logic [255:0] d);
    for (int i = 0; i < 32; i++) exp_bin.push_back({(i == 31), d[255-8*i -: 8]});
  endtask

  task automatic push_hex(input logic [255:0] d);
    for (int i = 0; i < 64; i++) exp_hex.push_back({1'b0, hex_char(d[255-4*i -: 4])});
    exp_hex.push_back({1'b1, 8'h0A});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_bin(input logic [255:0] d);
    bin_hash = d;
    bin_hv   = 1'b1;
    tick();
    bin_hv   = 1'b0;
  endtask

  task automatic wait_bin_idle(input string name);
    int n = 0;
    while (bin_busy && n < 500) begin
      tick();
      n++;
    end
    check(name, 32'(bin_busy), 32'd0);
  endtask

  // Compare every presented symbol with the scoreboard head; pop only on a handshake.
  always @(negedge clk) begin
    if (bin_valid === 1'b1) begin
      if (exp_bin.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL bin_extra: got 0x%0h, expected no symbol at %0t", bin_data, $time);
      end else begin
        check("bin_data", 32'(bin_data), 32'(exp_bin[0][7:0]));
        check("bin_last", 32'(bin_last), 32'(exp_bin[0][8]));
        if (rdy_bin) void'(exp_bin.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (hex_valid === 1'b1) begin
      if (exp_hex.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL hex_extra: got 0x%0h, expected no symbol at %0t", hex_data, $time);
      end else begin
        check("hex_data", 32'(hex_data), 32'(exp_hex[0][7:0]));
        check("hex_last", 32'(hex_last), 32'(exp_hex[0][8]));
        if (rdy_hex) void'(exp_hex.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_bin_valid", 32'(bin_valid), 32'd0);
    check("rst_bin_busy", 32'(bin_busy), 32'd0);
    check("rst_bin_ovr", 32'(bin_ovr), 32'd0);
    check("rst_bin_data", 32'(bin_data), 32'd0);
    check("rst_hex_valid", 32'(hex_valid), 32'd0);
    check("rst_hex_last", 32'(hex_last), 32'd0);

    // 1: binary streaming, ready always high
    rdy_bin = 1'b1;
    push_bin(ABC);
    pulse_bin(ABC);
    for (int i = 0; i < 32; i++) check("t1_valid_run", 32'(bin_valid), 32'd1);
    for (int i = 0; i < 32; i++) begin
      if (i == 0) check("t1_busy", 32'(bin_busy), 32'd1);
      if (i > 0) check("t1_valid_run", 32'(bin_valid), 32'd1);
      tick();
    end
    check("t1_busy_done", 32'(bin_busy), 32'd0);
    check("t1_valid_done", 32'(bin_valid), 32'd0);
    check("t1_queue", exp_bin.size(), 32'd0);

    // 2: hex with LF
    rdy_hex = 1'b1;
    push_hex(ABC);
    hex_hash = ABC;
    hex_hv   = 1'b1;
    tick();
    hex_hv   = 1'b0;
    for (int i = 0; i < 65; i++) begin
      check("t2_valid_run", 32'(hex_valid), 32'd1);
      tick();
    end
    check("t2_busy_done", 32'(hex_busy), 32'd0);
    check("t2_queue", exp_hex.size(), 32'd0);

    // 3: random stalls
    push_bin(ABC);
    pulse_bin(ABC);
    begin
      int n = 0;
      while (bin_busy && n < 600) begin
        rdy_bin = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
    end
    rdy_bin = 1'b1;
    check("t3_done", 32'(bin_busy), 32'd0);
    check("t3_queue", exp_bin.size(), 32'd0);

    // 4: dropped pulse mid-stream
    push_bin(ABC);
    pulse_bin(ABC);
    repeat (10) tick();
    check("t4_ovr_before", 32'(bin_ovr), 32'd0);
    pulse_bin(ONES);
    check("t4_ovr_set", 32'(bin_ovr), 32'd1);
    wait_bin_idle("t4_done");
    repeat (3) tick();
    check("t4_ovr_sticky", 32'(bin_ovr), 32'd1);
    check("t4_queue", exp_bin.size(), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_ovr_cleared", 32'(bin_ovr), 32'd0);

    // 5: pulse on the final handshake chains without a bubble
    push_bin(ABC);
    pulse_bin(ABC);
    repeat (31) tick();
    check("t5_last_present", 32'(bin_last), 32'd1);
    push_bin(ONES);
    pulse_bin(ONES);
    check("t5_valid", 32'(bin_valid), 32'd1);
    check("t5_data", 32'(bin_data), 32'h11);
    check("t5_ovr", 32'(bin_ovr), 32'd0);
    repeat (32) tick();
    check("t5_done", 32'(bin_busy), 32'd0);
    check("t5_queue", exp_bin.size(), 32'd0);

    // 6: reset mid-stream clears stream and overrun
    push_bin(ABC);
    pulse_bin(ABC);
    repeat (2) tick();
    pulse_bin(ONES);
    repeat (2) tick();
    check("t6_ovr_pre", 32'(bin_ovr), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_bin.delete();
    check("t6_valid", 32'(bin_valid), 32'd0);
    check("t6_busy", 32'(bin_busy), 32'd0);
    check("t6_ovr", 32'(bin_ovr), 32'd0);
    repeat (2) tick();
    check("t6_idle", 32'(bin_valid), 32'd0);
    push_bin(ABC);
    pulse_bin(ABC);
    check("t6_restart_data", 32'(bin_data), 32'hBA);
    repeat (32) tick();
    check("t6_done", 32'(bin_busy), 32'd0);
    check("t6_queue", exp_bin.size(), 32'd0);
    check("end_hex_queue", exp_hex.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
